// File: rtl/alu_op_sequencer_pkg.sv
// Shared types for the ALU request sequencer: opcode set, sequencer states,
// and helpers for opcode legality and per-opcode execution latency.
package alu_op_sequencer_pkg;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        MUL = 4'd2,
        DIV = 4'd3,
        SL  = 4'd4,
        SR  = 4'd5,
        AND = 4'd6,
        OR  = 4'd7,
        NOT = 4'd8,
        XOR = 4'd9
    } opcodes_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_t;

    function automatic logic op_is_legal(opcodes_t op);
        case (op)
            ADD, SUB, MUL, DIV, SL, SR, AND, OR, NOT, XOR: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    // Number of cycles the ALU inputs must be held before the result is valid.
    function automatic logic [3:0] op_latency(opcodes_t op,
                                              logic [3:0] mul_cycles,
                                              logic [3:0] div_cycles);
        case (op)
            MUL:     return mul_cycles;
            DIV:     return div_cycles;
            default: return 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Registers one ALU operation per handshake, holds it for the opcode's
// multicycle latency, then presents the captured result on a response port.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int unsigned DATASIZE   = 8,
    parameter int unsigned OUTPUTSIZE = 2 * DATASIZE,
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATASIZE-1:0]   req_in1,
    input  logic [DATASIZE-1:0]   req_in2,
    input  opcodes_t              req_opcode,
    output logic [DATASIZE-1:0]   alu_in1,
    output logic [DATASIZE-1:0]   alu_in2,
    output opcodes_t              alu_opcode,
    input  logic [OUTPUTSIZE-1:0] alu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [OUTPUTSIZE-1:0] rsp_result,
    output logic                  rsp_err,
    output logic                  busy
);

    seq_state_t            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATASIZE-1:0]   alu_in1_q, alu_in1_d;
    logic [DATASIZE-1:0]   alu_in2_q, alu_in2_d;
    opcodes_t              alu_opcode_q, alu_opcode_d;
    logic [OUTPUTSIZE-1:0] rsp_result_q, rsp_result_d;
    logic                  rsp_err_q, rsp_err_d;

    logic       accept;
    logic       req_err;
    logic [3:0] req_lat;

    // Gating with rst_n keeps req_ready low while reset is held, even though state is IDLE.
    assign req_ready = rst_n && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
    assign accept    = req_valid && req_ready;
    assign req_err   = !op_is_legal(req_opcode) || ((req_opcode == DIV) && (req_in2 == '0));
    assign req_lat   = op_latency(req_opcode, 4'(MUL_CYCLES), 4'(DIV_CYCLES));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_in1_d    = alu_in1_q;
        alu_in2_d    = alu_in2_q;
        alu_opcode_d = alu_opcode_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    alu_in1_d    = req_in1;
                    alu_in2_d    = req_in2;
                    alu_opcode_d = req_opcode;
                    // Faulting ops never reach the ALU's captured result path.
                    if (req_err) begin
                        rsp_result_d = '0;
                        rsp_err_d    = 1'b1;
                        state_d      = RESP;
                    end else begin
                        cnt_d   = req_lat - 4'd1;
                        state_d = EXEC;
                    end
                end else if ((state_q == RESP) && rsp_ready) begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    rsp_result_d = alu_result;
                    rsp_err_d    = 1'b0;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
            alu_opcode_q <= ADD;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_in1_q    <= alu_in1_d;
            alu_in2_q    <= alu_in2_d;
            alu_opcode_q <= alu_opcode_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_in1    = alu_in1_q;
    assign alu_in2    = alu_in2_q;
    assign alu_opcode = alu_opcode_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: an ALU model closes the loop and a
// negedge monitor checks every response, its latency and EXEC operand hold.
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    localparam int DATASIZE   = 8;
    localparam int OUTPUTSIZE = 16;
    localparam int MUL_CYCLES = 2;
    localparam int DIV_CYCLES = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic [DATASIZE-1:0]   req_in1 = '0;
    logic [DATASIZE-1:0]   req_in2 = '0;
    opcodes_t              req_opcode = ADD;
    logic [DATASIZE-1:0]   alu_in1;
    logic [DATASIZE-1:0]   alu_in2;
    opcodes_t              alu_opcode;
    logic [OUTPUTSIZE-1:0] alu_result;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [OUTPUTSIZE-1:0] rsp_result;
    logic                  rsp_err;
    logic                  busy;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  op;
        logic [15:0] res;
        logic        err;
        int          acceptCyc;
        int          lat;
    } exp_t;

    exp_t sbQueue[$];
    int   assertions = 0;
    int   failures   = 0;
    int   cyc        = 0;
    bit   headSeen   = 1'b0;
    bit   randReady  = 1'b0;

    alu_op_sequencer #(
        .DATASIZE  (DATASIZE),
        .OUTPUTSIZE(OUTPUTSIZE),
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .req_opcode(req_opcode),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_opcode(alu_opcode),
        .alu_result(alu_result),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Unsigned combinational ALU the sequencer drives.
    function automatic logic [15:0] aluModel(logic [3:0] op, logic [7:0] a, logic [7:0] b);
        logic [15:0] wa;
        logic [15:0] wb;
        wa = {8'h00, a};
        wb = {8'h00, b};
        case (op)
            4'd0:    return wa + wb;
            4'd1:    return wa - wb;
            4'd2:    return wa * wb;
            4'd3:    return (b == 8'h00) ? 16'h0000 : wa / wb;
            4'd4:    return wa << b;
            4'd5:    return wa >> b;
            4'd6:    return wa & wb;
            4'd7:    return wa | wb;
            4'd8:    return {8'h00, ~a};
            4'd9:    return wa ^ wb;
            default: return 16'h0000;
        endcase
    endfunction

    always_comb alu_result = aluModel(alu_opcode, alu_in1, alu_in2);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        assertions++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Drives one request, waits (bounded) for the handshake, logs the expectation.
    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 output int waits);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.op  = op;
        e.err = (op > 4'd9) || ((op == 4'd3) && (b == 8'h00));
        e.res = e.err ? 16'h0000 : aluModel(op, a, b);
        e.lat = e.err ? 1 : ((op == 4'd2) ? MUL_CYCLES : (op == 4'd3) ? DIV_CYCLES : 1) + 1;
        req_opcode = opcodes_t'(op);
        req_in1    = a;
        req_in2    = b;
        req_valid  = 1'b1;
        waits      = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            waits++;
            if (waits > 200) break;
        end
        if (waits > 200) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
        end else begin
            e.acceptCyc = cyc;
            sbQueue.push_back(e);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            req_in1   = 8'($urandom);
            req_in2   = 8'($urandom);
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((sbQueue.size() != 0) && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_empty", 32'(sbQueue.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"},  32'(req_ready),  32'd0);
        checkOutput({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
        checkOutput({tag, "_busy"},       32'(busy),       32'd0);
        checkOutput({tag, "_alu_in1"},    32'(alu_in1),    32'd0);
        checkOutput({tag, "_alu_in2"},    32'(alu_in2),    32'd0);
        checkOutput({tag, "_alu_opcode"}, 32'(alu_opcode), 32'(ADD));
        checkOutput({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
        checkOutput({tag, "_rsp_err"},    32'(rsp_err),    32'd0);
    endtask

    // Response monitor: order, latency, stability under backpressure, EXEC hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    if (!headSeen) begin
                        checkOutput("rsp_latency", 32'(cyc - sbQueue[0].acceptCyc), 32'(sbQueue[0].lat));
                        headSeen = 1'b1;
                    end
                    checkOutput("rsp_result", 32'(rsp_result), 32'(sbQueue[0].res));
                    checkOutput("rsp_err", 32'(rsp_err), 32'(sbQueue[0].err));
                    if (rsp_ready) begin
                        void'(sbQueue.pop_front());
                        headSeen = 1'b0;
                    end
                end
            end else if (busy && (sbQueue.size() != 0)) begin
                checkOutput("exec_alu_in1", 32'(alu_in1), 32'(sbQueue[0].a));
                checkOutput("exec_alu_in2", 32'(alu_in2), 32'(sbQueue[0].b));
                checkOutput("exec_alu_opcode", 32'(alu_opcode), 32'(sbQueue[0].op));
            end
        end
    end

    always @(posedge clk) begin
        if (randReady) begin
            #1;
            rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         w;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;

        #1;
        checkResetValues("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD, then DIV dropped by a mid-EXEC reset
        applyStimulus(ADD, 8'd3, 8'd4, w);
        waitDrain();
        applyStimulus(DIV, 8'd200, 8'd7, w);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkResetValues("midop_reset");
        sbQueue.delete();
        headSeen = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;

        // Multicycle and error ops
        applyStimulus(MUL, 8'hFF, 8'hFF, w);
        waitDrain();
        applyStimulus(DIV, 8'd200, 8'd7, w);
        waitDrain();
        applyStimulus(DIV, 8'd9, 8'd0, w);
        waitDrain();
        applyStimulus(4'hF, 8'h12, 8'h34, w);
        waitDrain();
        applyStimulus(NOT, 8'h5A, 8'h00, w);
        applyStimulus(SL, 8'h81, 8'd4, w);
        waitDrain();

        // Backpressure with a pending request that must be ignored
        rsp_ready = 1'b0;
        applyStimulus(SUB, 8'd5, 8'd3, w);
        w = 0;
        while (!rsp_valid && (w < 20)) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_opcode = ADD;
        req_in1    = 8'd1;
        req_in2    = 8'd1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
            checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        applyStimulus(XOR, 8'hF0, 8'h0F, w);
        checkOutput("bp_same_cycle_accept", 32'(w), 32'd0);
        waitDrain();

        // Random stream with random downstream readiness
        randReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            op = 4'($urandom_range(0, 11));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            applyStimulus(op, a, b, w);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        randReady = 1'b0;
        @(posedge clk);
        #2;
        rsp_ready = 1'b1;
        waitDrain();
        repeat (3) @(negedge clk);
        checkOutput("final_idle_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
